// File: rtl/sprite_engine.sv
// sprite_engine: N-sprite priority pixel engine with double-buffered
// sprite registers, a shared sprite ROM and a per-frame collision flag.
module sprite_engine #(
    parameter int N_SPR   = 4,
    parameter int SPR_W   = 64,
    parameter int SPR_H   = 64,
    parameter int COORD_W = 10,
    localparam int IW = (N_SPR > 1) ? $clog2(N_SPR) : 1,
    localparam int RW = $clog2(SPR_H),
    localparam int CW = $clog2(SPR_W),
    localparam int AW = $clog2(N_SPR) + RW + CW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pixelx,
    input  logic [COORD_W-1:0] pixely,
    input  logic               pixel_valid,
    input  logic               frame_start,
    input  logic               cfg_we,
    input  logic [IW-1:0]      cfg_idx,
    input  logic [COORD_W-1:0] cfg_posx,
    input  logic [COORD_W-1:0] cfg_posy,
    input  logic               cfg_en,
    input  logic               cfg_flipx,
    input  logic               cfg_scale2,
    output logic [AW-1:0]      rom_addr,
    input  logic [2:0]         rom_data,
    output logic [23:0]        RGB,
    output logic               visible,
    output logic               collision
);

    localparam int MW0  = (COORD_W > CW) ? COORD_W : CW;
    localparam int MW   = (MW0 > RW) ? MW0 : RW;
    localparam int CMPW = MW + 2;

    logic [N_SPR-1:0][COORD_W-1:0] pend_x_q, pend_x_d;
    logic [N_SPR-1:0][COORD_W-1:0] pend_y_q, pend_y_d;
    logic [N_SPR-1:0]              pend_en_q, pend_en_d;
    logic [N_SPR-1:0]              pend_fl_q, pend_fl_d;
    logic [N_SPR-1:0]              pend_sc_q, pend_sc_d;

    logic [N_SPR-1:0][COORD_W-1:0] act_x_q, act_x_d;
    logic [N_SPR-1:0][COORD_W-1:0] act_y_q, act_y_d;
    logic [N_SPR-1:0]              act_en_q, act_en_d;
    logic [N_SPR-1:0]              act_fl_q, act_fl_d;
    logic [N_SPR-1:0]              act_sc_q, act_sc_d;

    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          s1_win_q, s1_win_d;
    logic          s2_win_q, s2_win_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          visible_q, visible_d;
    logic          acc_q, acc_d;
    logic          collision_q, collision_d;

    logic [N_SPR-1:0]           hit;
    logic [N_SPR-1:0][CMPW-1:0] dx;
    logic [N_SPR-1:0][CMPW-1:0] dy;
    logic [N_SPR-1:0][CW-1:0]   col;
    logic [N_SPR-1:0][RW-1:0]   row;

    logic              any_hit;
    logic              overlap;
    logic [IW-1:0]     win_idx;
    logic [CW-1:0]     win_col;
    logic [RW-1:0]     win_row;
    logic [IW+RW+CW-1:0] addr_full;
    logic [23:0]       pal;

    always_comb begin
        pend_x_d  = pend_x_q;
        pend_y_d  = pend_y_q;
        pend_en_d = pend_en_q;
        pend_fl_d = pend_fl_q;
        pend_sc_d = pend_sc_q;
        if (cfg_we && (int'(cfg_idx) < N_SPR)) begin
            pend_x_d[cfg_idx]  = cfg_posx;
            pend_y_d[cfg_idx]  = cfg_posy;
            pend_en_d[cfg_idx] = cfg_en;
            pend_fl_d[cfg_idx] = cfg_flipx;
            pend_sc_d[cfg_idx] = cfg_scale2;
        end
    end

    // The swap copies the pre-write pending set.
    always_comb begin
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        act_en_d = act_en_q;
        act_fl_d = act_fl_q;
        act_sc_d = act_sc_q;
        if (frame_start) begin
            act_x_d  = pend_x_q;
            act_y_d  = pend_y_q;
            act_en_d = pend_en_q;
            act_fl_d = pend_fl_q;
            act_sc_d = pend_sc_q;
        end
    end

    always_comb begin
        hit = '0;
        dx  = '0;
        dy  = '0;
        col = '0;
        row = '0;
        for (int i = 0; i < N_SPR; i++) begin
            dx[i] = CMPW'(pixelx) - CMPW'(act_x_q[i]);
            dy[i] = CMPW'(pixely) - CMPW'(act_y_q[i]);
            hit[i] = act_en_q[i] && pixel_valid
                && (CMPW'(pixelx) >= CMPW'(act_x_q[i]))
                && (CMPW'(pixely) >= CMPW'(act_y_q[i]))
                && (dx[i] < (CMPW'(SPR_W) << act_sc_q[i]))
                && (dy[i] < (CMPW'(SPR_H) << act_sc_q[i]));
            col[i] = CW'(dx[i] >> act_sc_q[i]) ^ {CW{act_fl_q[i]}};
            row[i] = RW'(dy[i] >> act_sc_q[i]);
        end
    end

    always_comb begin
        any_hit = 1'b0;
        win_idx = '0;
        win_col = '0;
        win_row = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit = 1'b1;
                win_idx = IW'(i);
                win_col = col[i];
                win_row = row[i];
            end
        end
        overlap = (hit & (hit - 1'b1)) != '0;
    end

    always_comb begin
        case (rom_data)
            3'd1:    pal = 24'hFFFFFF;
            3'd2:    pal = 24'hFF0000;
            3'd3:    pal = 24'h00FF00;
            3'd4:    pal = 24'h0000FF;
            3'd5:    pal = 24'hFFFF00;
            3'd6:    pal = 24'h00FFFF;
            3'd7:    pal = 24'hFF00FF;
            default: pal = 24'h000000;
        endcase
    end

    always_comb begin
        addr_full   = {win_idx, win_row, win_col};
        rom_addr_d  = any_hit ? addr_full[AW-1:0] : rom_addr_q;
        s1_win_d    = any_hit;
        s2_win_d    = s1_win_q;
        rgb_d       = s2_win_q ? pal : 24'h000000;
        visible_d   = s2_win_q && (rom_data != 3'd0);
        acc_d       = frame_start ? 1'b0 : (acc_q | overlap);
        collision_d = frame_start ? (acc_q | overlap) : collision_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_en_q   <= '0;
            pend_fl_q   <= '0;
            pend_sc_q   <= '0;
            act_x_q     <= '0;
            act_y_q     <= '0;
            act_en_q    <= '0;
            act_fl_q    <= '0;
            act_sc_q    <= '0;
            rom_addr_q  <= '0;
            s1_win_q    <= 1'b0;
            s2_win_q    <= 1'b0;
            rgb_q       <= '0;
            visible_q   <= 1'b0;
            acc_q       <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_en_q   <= pend_en_d;
            pend_fl_q   <= pend_fl_d;
            pend_sc_q   <= pend_sc_d;
            act_x_q     <= act_x_d;
            act_y_q     <= act_y_d;
            act_en_q    <= act_en_d;
            act_fl_q    <= act_fl_d;
            act_sc_q    <= act_sc_d;
            rom_addr_q  <= rom_addr_d;
            s1_win_q    <= s1_win_d;
            s2_win_q    <= s2_win_d;
            rgb_q       <= rgb_d;
            visible_q   <= visible_d;
            acc_q       <= acc_d;
            collision_q <= collision_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign RGB       = rgb_q;
    assign visible   = visible_q;
    assign collision = collision_q;

endmodule

// File: doc/sprite_engine.md
# sprite_engine

Parametrised multi-sprite pixel engine: N sprites with per-sprite position, enable, horizontal flip and 2x scale, resolved by fixed priority into one RGB stream for the VGA pixel pipeline. Sprite images live in one shared external synchronous ROM addressed by {sprite index, row, column}. Position and mode registers are double-buffered and swap only at frame start, so sprite updates never tear mid-frame. A bounding-box collision flag is produced per frame for game logic.

## Interface
- N_SPR, 4: number of sprites, 1..8.
- SPR_W, 64: sprite width in pixels, power of two.
- SPR_H, 64: sprite height in pixels, power of two.
- COORD_W, 10: pixel and position coordinate width.
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pixelx, pixely  in  COORD_W each  current raster coordinate.
- pixel_valid  in  1  coordinate is inside the active area.
- frame_start  in  1  one-cycle pulse; swaps shadow registers into the active set.
- cfg_we  in  1  write strobe for the sprite configuration.
- cfg_idx  in  clog2(N_SPR), minimum 1  sprite written.
- cfg_posx, cfg_posy  in  COORD_W each  top-left corner.
- cfg_en, cfg_flipx, cfg_scale2  in  1 each  enable, mirror columns, double pixel size.
- rom_addr  out  AW = clog2(N_SPR)+clog2(SPR_H)+clog2(SPR_W)  {idx, row, col}.
- rom_data  in  3  ROM colour index, valid one cycle after rom_addr.
- RGB  out  24  output colour.
- visible  out  1  sprite pixel is opaque at this position.
- collision  out  1  previous frame had overlap of at least two enabled sprites.

## Operation
- Pending register set: cfg_we writes pending[cfg_idx] and is accepted every cycle, no backpressure. An out-of-range cfg_idx is ignored.
- Active register set: on frame_start, active <= pending. If cfg_we and frame_start occur in the same cycle, the copy uses the pre-write pending value; the write takes effect at the following frame_start.
- Extent per sprite: E_W = SPR_W << scale2, E_H = SPR_H << scale2.
- Hit rule for sprite i: en, pixel_valid, pixelx >= posx, pixely >= posy, dx = pixelx - posx < E_W, dy = pixely - posy < E_H.
  - Compares are unsigned and at least COORD_W+2 bits wide, so sprites near the right or bottom edge do not wrap.
- Winner: the lowest-index sprite that hits. Only the winner's ROM pixel is shown. A transparent winner pixel shows background, not a lower-priority sprite.
- Column = dx >> scale2, XOR (SPR_W-1) when flipx. Row = dy >> scale2.
- Palette, with colour 0 transparent: 0 = 000000, 1 = FFFFFF, 2 = FF0000, 3 = 00FF00, 4 = 0000FF, 5 = FFFF00, 6 = 00FFFF, 7 = FF00FF.
- visible = 1 when there is a winner and rom_data != 0; otherwise visible = 0 and RGB = 000000.
- Collision accumulation: the accumulator sets when two or more sprites hit the same valid pixel.
  - On frame_start, collision <= accumulator OR the current cycle's overlap, and the accumulator clears.
  - An overlap in the cycle after frame_start counts toward the new frame.

## Timing
- Cycle t: pixelx, pixely and pixel_valid are sampled.
- Cycle t+1: rom_addr is registered, together with the pipeline tags hit, pixel_valid and rgb-enable.
- Cycle t+2: ROM returns rom_data and the tags advance.
- Cycle t+3: RGB and visible are registered. Fixed latency is 3 cycles with no bubbles: one pixel in and one out every cycle.
- With no winner, rom_addr holds its previous value. The winner tag, not rom_addr, gates the output.
- frame_start affects hit decisions for coordinates sampled in the cycle after the pulse and later.
- Reset (asynchronous, any time):
  - All active and pending registers clear, which leaves all sprites disabled.
  - Pipeline tags, accumulator, collision, rom_addr, RGB and visible go to 0 immediately.
  - The first valid output is 3 cycles after reset release and input.

## Test plan
- Basic hit:
  - Stimulus: sprite 0 at (100,50), enable, swap; raster pixel (100,50); ROM returns 1.
  - Response: rom_addr = 0 at t+1; RGB = FFFFFF and visible = 1 at t+3.
  - Pixel (164,50) must give visible = 0.
- Scale and flip:
  - Stimulus: sprite 1 at (0,0) with scale2 and flipx; pixel (5,9).
  - Response: rom_addr = {1, row 4, col 61}.
  - Pixel (127,127) hits; (128,0) misses.
- Priority and transparency:
  - Stimulus: sprites 0 and 2 both cover (200,200); ROM returns 0 for sprite 0.
  - Response: rom_addr index = 0 and visible = 0; sprite 2 is not shown.
  - collision = 1 after the next frame_start.
- Double buffering:
  - Stimulus: write sprite 0 posx = 300 mid-frame.
  - Response: hits stay at the old position until frame_start.
  - A write coincident with frame_start becomes active only at the second frame_start.
- Edge:
  - Stimulus: posx = 1000 with COORD_W = 10.
  - Response: pixels 1000..1023 hit; pixels 0..39 do not (no wrap).
- Reset:
  - Stimulus: assert rst_n low while visible = 1.
  - Response: visible, RGB and collision drop to 0 in the same cycle, and no sprites are enabled after release.
